mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 40 ++++
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_mdu_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared md_op encodings, FSM state type and op-class helpers for the multiply/divide unit.
package mdu_ctrl_pkg;

  localparam logic [3:0] mdNone  = 4'd0;
  localparam logic [3:0] mdMult  = 4'd1;
  localparam logic [3:0] mdMultu = 4'd2;
  localparam logic [3:0] mdDiv   = 4'd3;
  localparam logic [3:0] mdDivu  = 4'd4;
  localparam logic [3:0] mdMthi  = 4'd5;
  localparam logic [3:0] mdMtlo  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == mdMult) || (op == mdMultu);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == mdDiv) || (op == mdDivu);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == mdMult) || (op == mdDiv);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder of the held operands.
// The divider exists only when MDU_DIV_EN is defined; otherwise quot/rem are tied to zero.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  // Product always; quotient/remainder only in divider builds.
  always_comb begin
    prod = 64'd0;
    quot = 32'd0;
    rem  = 32'd0;
    if (signed_op) begin
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    end else begin
      prod = {32'd0, a} * {32'd0, b};
    end
`ifdef MDU_DIV_EN
    // Zero divisor yields no result; the controller suppresses the write.
    if (b == 32'd0) begin
      quot = 32'd0;
      rem  = 32'd0;
    end else if (signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else if (signed_op) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end else begin
      quot = a / b;
      rem  = a % b;
    end
`endif
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller for mult/multu/div/divu and mthi/mtlo.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] md_A,
  input  logic [31:0] md_B,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      a_r, a_s, b_r, b_s, hi_r, hi_s, lo_r, lo_s;
  logic             signed_r, signed_s, busy_r, busy_s;
  logic             go_mult_s, go_div_s;
  logic [63:0]      prod_s;
  logic [31:0]      quot_s, rem_s;

  mdu_arith u_arith (
    .a         (a_r),
    .b         (b_r),
    .signed_op (signed_r),
    .prod      (prod_s),
    .quot      (quot_s),
    .rem       (rem_s)
  );

  assign go_mult_s = start && !req && is_mult_op(md_op);
`ifdef MDU_DIV_EN
  assign go_div_s  = start && !req && is_div_op(md_op);
`else
  assign go_div_s  = 1'b0;
`endif

  // Next-state, counter, operand capture and HI/LO update.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    signed_s = signed_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    busy_s   = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (go_mult_s || go_div_s) begin
          state_s  = go_mult_s ? ST_MULT : ST_DIV;
          cnt_s    = go_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          a_s      = md_A;
          b_s      = md_B;
          signed_s = is_signed_op(md_op);
          busy_s   = 1'b1;
        end else if (!req && (md_op == mdMthi)) begin
          hi_s = md_A;
        end else if (!req && (md_op == mdMtlo)) begin
          lo_s = md_A;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_MULT, ST_DIV: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_W'(0);
          busy_s  = 1'b0;
          if (state_r == ST_MULT) begin
            hi_s = prod_s[63:32];
            lo_s = prod_s[31:0];
          end else if (b_r != 32'd0) begin
            hi_s = rem_s;
            lo_s = quot_s;
          end else begin
            hi_s = hi_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_W'(0);
        busy_s  = 1'b0;
      end
    endcase
  end

  // Register bank; reset drops any in-flight operation without touching HI/LO beyond clearing them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_W'(0);
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      signed_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
      signed_r <= signed_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
      busy_r   <= busy_s;
    end
  end

  assign busy   = busy_r;
  assign hi_out = hi_r;
  assign lo_out = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic HI/LO reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, req, busy;
  logic [3:0]  md_op;
  logic [31:0] md_A, md_B, hi_out, lo_out;
  logic [31:0] exp_hi, exp_lo;
  int          vectors = 0;
  int          miscompares = 0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start), .req(req),
    .md_A(md_A), .md_B(md_B), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_busy);
    chk({tag, "/busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, "/hi"}, hi_out, exp_hi);
    chk({tag, "/lo"}, lo_out, exp_lo);
  endtask

  // Reference result: updates exp_hi/exp_lo from the operation's arithmetic definition.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (op == mdMult || op == mdDiv) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (op == mdMult || op == mdMultu) begin
      p = 64'(sa * sb);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b != 32'd0) begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  // Launch an accepted op, poke ignored traffic while busy, then check the result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cycles, input int req_at, input string tag);
    @(negedge clk);
    md_op = op; start = 1'b1; md_A = a; md_B = b;
    @(negedge clk);
    for (int k = 1; k <= cycles; k++) begin
      chk_state($sformatf("%s/c%0d", tag, k), 1'b1);
      start = 1'b0; md_op = mdNone; req = (k == req_at);
      md_A = $urandom; md_B = $urandom;
      if (k == 2) md_op = mdMthi;
      if (k == cycles) begin
        start = 1'b1; md_op = mdMult;
      end
      @(negedge clk);
    end
    start = 1'b0; md_op = mdNone; req = 1'b0;
    model(op, a, b);
    chk_state({tag, "/done"}, 1'b0);
  endtask

  // Present a request that must have no effect at all.
  task automatic run_ignored(input logic [3:0] op, input logic st, input logic rq,
                             input logic [31:0] a, input string tag);
    @(negedge clk);
    md_op = op; start = st; req = rq; md_A = a; md_B = 32'd7;
    @(negedge clk);
    md_op = mdNone; start = 1'b0; req = 1'b0;
    chk_state(tag, 1'b0);
    @(negedge clk);
    chk_state({tag, "/+1"}, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; req = 1'b0; md_op = mdNone; md_A = 32'd0; md_B = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_state("reset", 1'b0);

    run_op(mdMult,  32'hFFFF_FFFE, 32'd3, MC, 0, "mult_neg");
    chk("mult_neg_hi_const", hi_out, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo_out, 32'hFFFF_FFFA);
    run_op(mdMultu, 32'hFFFF_FFFF, 32'd2, MC, 0, "multu");
    chk("multu_hi_const", hi_out, 32'd1);
    chk("multu_lo_const", lo_out, 32'hFFFF_FFFE);

    run_ignored(mdMult, 1'b1, 1'b1, 32'd9, "start_req");
    run_op(mdMultu, 32'd1000, 32'd77, MC, 3, "req_inflight");
    run_ignored(mdMthi, 1'b0, 1'b1, 32'hDEAD_BEEF, "mthi_req");

    @(negedge clk);
    md_op = mdMthi; md_A = 32'h1234_5678;
    @(negedge clk);
    md_op = mdNone; exp_hi = 32'h1234_5678;
    chk_state("mthi_idle", 1'b0);
    @(negedge clk);
    md_op = mdMtlo; md_A = 32'hCAFE_0001;
    @(negedge clk);
    md_op = mdNone; exp_lo = 32'hCAFE_0001;
    chk_state("mtlo_idle", 1'b0);

`ifdef MDU_DIV_EN
    run_op(mdDiv,  32'hFFFF_FFF9, 32'd2, DC, 0, "div_neg");
    chk("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", hi_out, 32'hFFFF_FFFF);
    run_op(mdDivu, 32'd5, 32'd0, DC, 0, "divu_zero");
    run_op(mdDiv,  32'h8000_0000, 32'hFFFF_FFFF, DC, 0, "div_ovf");
    chk("div_ovf_lo_const", lo_out, 32'h8000_0000);
    chk("div_ovf_hi_const", hi_out, 32'd0);
`else
    run_ignored(mdDiv,  1'b1, 1'b0, 32'd7, "div_off");
    run_ignored(mdDivu, 1'b1, 1'b0, 32'd5, "divu_off");
`endif

    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i % 3 == 1) rb = 32'($urandom_range(1, 300));
`ifdef MDU_DIV_EN
      run_op(op, ra, rb, is_div_op(op) ? DC : MC, (i % 2 == 0) ? 4 : 0, $sformatf("rnd%0d", i));
`else
      if (is_div_op(op)) run_ignored(op, 1'b1, 1'b0, ra, $sformatf("rnd%0d_off", i));
      else run_op(op, ra, rb, MC, (i % 2 == 0) ? 4 : 0, $sformatf("rnd%0d", i));
`endif
    end

    // Reset two cycles into an operation, with a competing mtlo.
    @(negedge clk);
`ifdef MDU_DIV_EN
    md_op = mdDiv;
`else
    md_op = mdMult;
`endif
    start = 1'b1; md_A = 32'hFFFF_FFF9; md_B = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = mdNone;
    chk("rst_mid/busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0; md_op = mdMtlo; md_A = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b1; md_op = mdNone;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk_state("rst_mid", 1'b0);
    repeat (DC + 2) @(negedge clk);
    chk_state("rst_mid/after", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
